// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch stage: common scalar types and the reset PC,
// plus the pipeline-facing fetch enums.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
endpackage

package pipes;
  typedef enum logic {
    INSTR_CONTINUE = 1'b0,
    INSTR_MAINTAIN = 1'b1
  } instr_FETCH_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the instruction-bus
// handshake, buffers one instruction under stall and applies redirects.
module fetch_ctrl
  import common::*;
  import pipes::*;
#(
  parameter u64 PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_addr_ok,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic [63:0]  pc,
  output logic [31:0]  raw_instr,
  output logic         ivalid,
  output instr_FETCH_t instr_fetch,
  output logic         iwait
);

  fetch_state_t state, state_d;
  u64           pc_q, pc_d;
  u32           instr_q, instr_d;
  u64           pend_pc, pend_d;

  // Address acceptance carries no information the sequencer needs.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp_addr_ok;

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    instr_d = instr_q;
    pend_d  = pend_pc;
    case (state)
      S_FETCH: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            instr_d = iresp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pend_d  = redirect_pc;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A redirect landing together with the stale data_ok is the newest target.
        if (iresp_data_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc;
          state_d = S_FETCH;
        end else if (redirect_valid) begin
          pend_d = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pend_pc <= '0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pend_pc <= pend_d;
    end
  end

  // Data returned while nothing is outstanding means the bus broke protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(state == S_HOLD && iresp_data_ok));
    end
  end

  // Request/valid outputs are forced quiet during the reset cycle.
  assign ireq_valid  = !reset && (state != S_HOLD);
  assign iwait       = !reset && (state != S_HOLD);
  assign ivalid      = !reset && (state == S_HOLD);
  assign ireq_addr   = pc_q;
  assign pc          = pc_q;
  assign raw_instr   = instr_q;
  assign instr_fetch = (!reset && state == S_HOLD && stall && !redirect_valid)
                       ? INSTR_MAINTAIN : INSTR_CONTINUE;

endmodule
